multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I control unit.
// Accepts one instruction word at a time, decodes it and sequences it
// through FETCH -> DECODE -> EXEC -> (MEM) -> WB, driving datapath selects and
// strobes. Illegal instructions park the FSM in TRAP, and ECALL/EBREAK park
// it in HALT. Only reset leaves either state.
//
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   instruction, instr_valid  instruction word and its valid flag
//   instr_ready               high in FETCH: controller takes a word
//   mem_ready                 data memory access complete
//   write_en, pc_write        register file and PC write strobes (WB only)
//   mem_read, mem_write       load/store request, held through MEM
//   alu_sel, alu_a_sel, alu_b_sel, load_store_type, load_unsigned,
//   write_src_sel, branch_type
//                             IR-decoded datapath controls (EXEC/MEM/WB)
//   illegal, halted           sticky trap / halt indicators
//
// state  | meaning
// FETCH  | wait for instr_valid, latch IR
// DECODE | classify IR: illegal, system, or normal
// EXEC   | ALU operation
// MEM    | load/store request until mem_ready
// WB     | register write-back and PC update, one cycle
// TRAP   | illegal instruction, absorbing
// HALT   | ECALL/EBREAK executed, absorbing
module multicycle_ctrl #(
    parameter int ALU_SEL_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [31:0]              instruction,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic                     mem_ready,
    output logic                     write_en,
    output logic [ALU_SEL_WIDTH-1:0] alu_sel,
    output logic                     alu_a_sel,
    output logic                     alu_b_sel,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [1:0]               load_store_type,
    output logic                     load_unsigned,
    output logic [1:0]               write_src_sel,
    output logic [2:0]               branch_type,
    output logic                     pc_write,
    output logic                     illegal,
    output logic                     halted
);

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, TRAP, HALT
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_FENCE  = 7'h0F;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    localparam logic [ALU_SEL_WIDTH-1:0] ALU_ADD   = ALU_SEL_WIDTH'(0);
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_SUB   = ALU_SEL_WIDTH'(1);
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_SLL   = ALU_SEL_WIDTH'(2);
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_SLT   = ALU_SEL_WIDTH'(3);
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_SLTU  = ALU_SEL_WIDTH'(4);
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_XOR   = ALU_SEL_WIDTH'(5);
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_SRL   = ALU_SEL_WIDTH'(6);
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_SRA   = ALU_SEL_WIDTH'(7);
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_OR    = ALU_SEL_WIDTH'(8);
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_AND   = ALU_SEL_WIDTH'(9);
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_PASSB = ALU_SEL_WIDTH'(10);

    state_t      state, state_next;
    logic [31:0] ir;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       unused_ir_bits;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];
    // Register and immediate fields feed the datapath, not the controller.
    assign unused_ir_bits = ^ir[24:15];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= FETCH;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (state == FETCH && instr_valid) begin
                ir <= instruction;
            end
        end
    end

    logic ir_illegal;

    always_comb begin
        ir_illegal = 1'b0;
        unique case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_FENCE, OPC_SYSTEM:
                ir_illegal = 1'b0;
            OPC_LOAD:   ir_illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
            OPC_STORE:  ir_illegal = (funct3 > 3'd2);
            OPC_BRANCH: ir_illegal = (funct3 == 3'd2) || (funct3 == 3'd3);
            OPC_OP:     ir_illegal = !((funct7 == 7'h00) ||
                                       ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5))));
            OPC_OPIMM:  ir_illegal = (funct3 == 3'd5) && (funct7 != 7'h00) && (funct7 != 7'h20);
            default:    ir_illegal = 1'b1;
        endcase
    end

    // Integer ALU op from funct3; alt selects SUB/SRA.
    function automatic logic [ALU_SEL_WIDTH-1:0] int_alu_op(input logic [2:0] f3, input logic alt);
        logic [ALU_SEL_WIDTH-1:0] op;
        op = ALU_ADD;
        case (f3)
            3'd0: op = alt ? ALU_SUB : ALU_ADD;
            3'd1: op = ALU_SLL;
            3'd2: op = ALU_SLT;
            3'd3: op = ALU_SLTU;
            3'd4: op = ALU_XOR;
            3'd5: op = alt ? ALU_SRA : ALU_SRL;
            3'd6: op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [ALU_SEL_WIDTH-1:0] dec_alu;
    logic                     dec_a, dec_b, dec_lu, dec_we;
    logic [1:0]               dec_lst, dec_wsrc;
    logic [2:0]               dec_bt;

    always_comb begin
        dec_alu  = ALU_ADD;
        dec_a    = 1'b0;
        dec_b    = 1'b0;
        dec_lst  = 2'd0;
        dec_lu   = 1'b0;
        dec_wsrc = 2'd0;
        dec_bt   = 3'd0;
        dec_we   = 1'b0;
        unique case (opcode)
            OPC_LUI: begin
                dec_alu = ALU_PASSB;
                dec_b   = 1'b1;
                dec_we  = 1'b1;
            end
            OPC_AUIPC: begin
                dec_a  = 1'b1;
                dec_b  = 1'b1;
                dec_we = 1'b1;
            end
            OPC_JAL: begin
                dec_a    = 1'b1;
                dec_b    = 1'b1;
                dec_wsrc = 2'd2;
                dec_bt   = 3'd7;
                dec_we   = 1'b1;
            end
            OPC_JALR: begin
                dec_b    = 1'b1;
                dec_wsrc = 2'd2;
                dec_bt   = 3'd7;
                dec_we   = 1'b1;
            end
            OPC_BRANCH: begin
                dec_a = 1'b1;
                dec_b = 1'b1;
                case (funct3)
                    3'd0:    dec_bt = 3'd1;
                    3'd1:    dec_bt = 3'd2;
                    3'd4:    dec_bt = 3'd3;
                    3'd5:    dec_bt = 3'd4;
                    3'd6:    dec_bt = 3'd5;
                    3'd7:    dec_bt = 3'd6;
                    default: dec_bt = 3'd0;
                endcase
            end
            OPC_LOAD: begin
                dec_b    = 1'b1;
                dec_lst  = funct3[1:0];
                dec_lu   = funct3[2];
                dec_wsrc = 2'd1;
                dec_we   = 1'b1;
            end
            OPC_STORE: begin
                dec_b   = 1'b1;
                dec_lst = funct3[1:0];
            end
            OPC_OPIMM: begin
                // Only the shift-right immediate form carries a funct7 qualifier.
                dec_alu = int_alu_op(funct3, (funct3 == 3'd5) && funct7[5]);
                dec_b   = 1'b1;
                dec_we  = 1'b1;
            end
            OPC_OP: begin
                dec_alu = int_alu_op(funct3, funct7[5]);
                dec_we  = 1'b1;
            end
            default: ;
        endcase
        if (rd == 5'd0) begin
            dec_we = 1'b0;
        end
    end

    always_comb begin
        state_next      = state;
        instr_ready     = 1'b0;
        write_en        = 1'b0;
        alu_sel         = '0;
        alu_a_sel       = 1'b0;
        alu_b_sel       = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        load_store_type = 2'd0;
        load_unsigned   = 1'b0;
        write_src_sel   = 2'd0;
        branch_type     = 3'd0;
        pc_write        = 1'b0;
        illegal         = 1'b0;
        halted          = 1'b0;

        if (state == EXEC || state == MEM || state == WB) begin
            alu_sel         = dec_alu;
            alu_a_sel       = dec_a;
            alu_b_sel       = dec_b;
            load_store_type = dec_lst;
            load_unsigned   = dec_lu;
            write_src_sel   = dec_wsrc;
            branch_type     = dec_bt;
        end

        unique case (state)
            FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) state_next = DECODE;
            end
            DECODE: begin
                if (ir_illegal)                 state_next = TRAP;
                else if (opcode == OPC_SYSTEM)  state_next = HALT;
                else                            state_next = EXEC;
            end
            EXEC: begin
                if (opcode == OPC_LOAD || opcode == OPC_STORE) state_next = MEM;
                else                                           state_next = WB;
            end
            MEM: begin
                mem_read  = (opcode == OPC_LOAD);
                mem_write = (opcode == OPC_STORE);
                if (mem_ready) state_next = WB;
            end
            WB: begin
                pc_write   = 1'b1;
                write_en   = dec_we;
                state_next = FETCH;
            end
            TRAP:    illegal = 1'b1;
            HALT:    halted  = 1'b1;
            default: state_next = FETCH;
        endcase

        // Reset silences every output immediately, including a pending memory request.
        if (!rstn) begin
            instr_ready     = 1'b0;
            write_en        = 1'b0;
            alu_sel         = '0;
            alu_a_sel       = 1'b0;
            alu_b_sel       = 1'b0;
            mem_read        = 1'b0;
            mem_write       = 1'b0;
            load_store_type = 2'd0;
            load_unsigned   = 1'b0;
            write_src_sel   = 2'd0;
            branch_type     = 3'd0;
            pc_write        = 1'b0;
            illegal         = 1'b0;
            halted          = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl.
// The stimulus process pushes the expected write-back / trap / halt response
// for each issued instruction; the monitor pops and compares on each event.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic        mem_ready;
    logic        write_en;
    logic [3:0]  alu_sel;
    logic        alu_a_sel, alu_b_sel, mem_read, mem_write;
    logic [1:0]  load_store_type;
    logic        load_unsigned;
    logic [1:0]  write_src_sel;
    logic [2:0]  branch_type;
    logic        pc_write, illegal, halted;

    multicycle_ctrl #(.ALU_SEL_WIDTH(4)) dut (
        .clk(clk), .rstn(rstn), .instruction(instruction), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .mem_ready(mem_ready), .write_en(write_en),
        .alu_sel(alu_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .mem_read(mem_read), .mem_write(mem_write), .load_store_type(load_store_type),
        .load_unsigned(load_unsigned), .write_src_sel(write_src_sel),
        .branch_type(branch_type), .pc_write(pc_write), .illegal(illegal), .halted(halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // {we, alu[3:0], a, b, lst[1:0], lu, wsrc[1:0], bt[2:0]}
    function automatic logic [14:0] mk(input logic we, input logic [3:0] alu, input logic a,
                                       input logic b, input logic [1:0] lst, input logic lu,
                                       input logic [1:0] wsrc, input logic [2:0] bt);
        return {we, alu, a, b, lst, lu, wsrc, bt};
    endfunction

    typedef struct {
        int          kind;   // 0 write-back, 1 trap, 2 halt
        logic [14:0] fields;
        int          rd_cycles;
        int          wr_cycles;
    } exp_t;

    exp_t exp_q[$];

    // ---------------- monitor ----------------
    int          cyc = 0;
    int          acc_cyc = 0;
    bit          tracking = 0;
    int          rd_cnt = 0, wr_cnt = 0;
    logic [14:0] exec_snap = '0;
    bit          ill_q = 0, hlt_q = 0, rdy_pending = 0;
    logic [14:0] act_fields;

    assign act_fields = {write_en, alu_sel, alu_a_sel, alu_b_sel, load_store_type,
                         load_unsigned, write_src_sel, branch_type};

    task automatic handle_event(input int kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event actual=kind%0d expected=none", kind);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", kind, e.kind);
        if (kind == 0 && e.kind == 0) begin
            chk("wb_fields", act_fields, e.fields);
            chk("exec_fields_stable", exec_snap[13:0], e.fields[13:0]);
            chk("mem_read_cycles", rd_cnt, e.rd_cycles);
            chk("mem_write_cycles", wr_cnt, e.wr_cycles);
            chk("wb_latency", cyc - acc_cyc, 3 + e.rd_cycles + e.wr_cycles);
            rdy_pending = 1;
        end else if (kind != 0) begin
            chk("park_latency", cyc - acc_cyc, 2);
            chk("park_ready", instr_ready, 0);
            chk("park_strobes", {pc_write, write_en, mem_read, mem_write}, 0);
        end
        tracking = 0;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rstn) begin
            tracking    = 0;
            ill_q       = 0;
            hlt_q       = 0;
            rdy_pending = 0;
        end else begin
            if (rdy_pending) begin
                chk("ready_after_wb", instr_ready, 1);
                rdy_pending = 0;
            end
            if (instr_ready && instr_valid) begin
                tracking = 1;
                acc_cyc  = cyc;
                rd_cnt   = 0;
                wr_cnt   = 0;
            end
            if (mem_read)  rd_cnt++;
            if (mem_write) wr_cnt++;
            if (tracking && cyc == acc_cyc + 2) exec_snap = act_fields;
            if (pc_write)            handle_event(0);
            if (illegal && !ill_q)   handle_event(1);
            if (halted && !hlt_q)    handle_event(2);
            ill_q = illegal;
            hlt_q = halted;
        end
    end

    // ---------------- stimulus ----------------
    task automatic sb_push(input int kind, input logic [14:0] f, input int rd, input int wr);
        exp_t e;
        e.kind = kind; e.fields = f; e.rd_cycles = rd; e.wr_cycles = wr;
        exp_q.push_back(e);
    endtask

    // Entered and left at posedge+1. n_mem>0 answers mem_ready on the n_mem-th MEM cycle.
    task automatic issue(input logic [31:0] ins, input int n_mem);
        int t;
        t = 0;
        @(posedge clk); #1;
        while (!instr_ready && t < 50) begin @(posedge clk); #1; t++; end
        if (!instr_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout actual=ready0 expected=ready1 ins=%h", ins);
            return;
        end
        instruction = ins;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        if (n_mem > 0) begin
            t = 0;
            while (!(mem_read || mem_write) && t < 20) begin @(posedge clk); #1; t++; end
            if (!(mem_read || mem_write)) begin
                checks++; errors++;
                $display("FAIL mem_timeout actual=idle expected=request ins=%h", ins);
                return;
            end
            repeat (n_mem - 1) begin @(posedge clk); #1; end
            mem_ready = 1'b1;
            @(posedge clk); #1;
            mem_ready = 1'b0;
        end
    endtask

    task automatic wait_flag(input string name, input bit want_illegal);
        int t;
        t = 0;
        while (!(want_illegal ? illegal : halted) && t < 20) begin @(posedge clk); #1; t++; end
        chk(name, want_illegal ? illegal : halted, 1);
    endtask

    // Entered and left at posedge+1.
    task automatic do_reset();
        rstn = 1'b0; instr_valid = 1'b0; mem_ready = 1'b0;
        #1;
        chk("rst_forced_ready", instr_ready, 0);
        chk("rst_forced_flags", {illegal, halted, mem_read, mem_write, pc_write}, 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", instr_ready, 1);
        chk("post_rst_illegal", illegal, 0);
        chk("post_rst_halted", halted, 0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [14:0] f;
        int          rd;
        int          wr;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int t;
        rstn = 1'b0; instr_valid = 1'b0; mem_ready = 1'b0; instruction = '0;

        //               instruction   we alu a  b  lst lu wsrc bt              rd wr
        vecs.push_back('{32'h00500093, mk(1, 0, 0, 1, 0, 0, 0, 0), 0, 0}); // ADDI x1,x0,5
        vecs.push_back('{32'h0000A103, mk(1, 0, 0, 1, 2, 0, 1, 0), 4, 0}); // LW x2,0(x1)
        vecs.push_back('{32'h0020A223, mk(0, 0, 0, 1, 2, 0, 0, 0), 0, 1}); // SW x2,4(x1)
        vecs.push_back('{32'h00000463, mk(0, 0, 1, 1, 0, 0, 0, 1), 0, 0}); // BEQ x0,x0,8
        vecs.push_back('{32'h0000000F, mk(0, 0, 0, 0, 0, 0, 0, 0), 0, 0}); // FENCE
        vecs.push_back('{32'h402081B3, mk(1, 1, 0, 0, 0, 0, 0, 0), 0, 0}); // SUB x3,x1,x2
        vecs.push_back('{32'h40335293, mk(1, 7, 0, 1, 0, 0, 0, 0), 0, 0}); // SRAI x5,x6,3
        vecs.push_back('{32'h00114383, mk(1, 0, 0, 1, 0, 1, 1, 0), 2, 0}); // LBU x7,1(x2)
        vecs.push_back('{32'h00209123, mk(0, 0, 0, 1, 1, 0, 0, 0), 0, 3}); // SH x2,2(x1)
        vecs.push_back('{32'h010000EF, mk(1, 0, 1, 1, 0, 0, 2, 7), 0, 0}); // JAL x1,16
        vecs.push_back('{32'h00008067, mk(0, 0, 0, 1, 0, 0, 2, 7), 0, 0}); // JALR x0,0(x1)
        vecs.push_back('{32'h0020F033, mk(0, 9, 0, 0, 0, 0, 0, 0), 0, 0}); // AND x0,x1,x2
        vecs.push_back('{32'h12345237, mk(1, 10, 0, 1, 0, 0, 0, 0), 0, 0}); // LUI x4,0x12345
        vecs.push_back('{32'h0020F463, mk(0, 0, 1, 1, 0, 0, 0, 6), 0, 0}); // BGEU x1,x2,8

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready_low", instr_ready, 0);
        chk("reset_outputs_low", act_fields, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("first_fetch_ready", instr_ready, 1);
        chk("first_fetch_flags", {illegal, halted, pc_write}, 0);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            sb_push(0, vecs[i].f, vecs[i].rd, vecs[i].wr);
            issue(vecs[i].ins, vecs[i].rd + vecs[i].wr);
        end

        // All-zero word traps and stays trapped
        sb_push(1, '0, 0, 0);
        issue(32'h00000000, 0);
        wait_flag("trap_reached", 1'b1);
        instr_valid = 1'b1;
        instruction = 32'h00500093;
        repeat (6) begin @(posedge clk); #1; end
        chk("trap_sticky_illegal", illegal, 1);
        chk("trap_sticky_ready", instr_ready, 0);
        chk("trap_no_pc_write", pc_write, 0);
        instr_valid = 1'b0;
        do_reset();

        // OP with funct7=0x01 is not a legal base-ISA op
        sb_push(1, '0, 0, 0);
        issue(32'h02208133, 0);
        wait_flag("op_funct7_trap", 1'b1);
        @(posedge clk); #1;
        do_reset();

        // ECALL halts with no PC update
        sb_push(2, '0, 0, 0);
        issue(32'h00000073, 0);
        wait_flag("halt_reached", 1'b0);
        repeat (5) begin @(posedge clk); #1; end
        chk("halt_sticky", halted, 1);
        chk("halt_no_pc_write", pc_write, 0);
        chk("halt_ready_low", instr_ready, 0);
        do_reset();

        // Reset in the middle of a load
        issue(32'h0000A103, 0);
        t = 0;
        while (!mem_read && t < 20) begin @(posedge clk); #1; t++; end
        chk("mem_read_before_rst", mem_read, 1);
        @(posedge clk); #1;
        do_reset();

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
